// File: rtl/ld_pkg.sv
// ld_pkg: shared definitions for the load path.
//   - RV32I load funct3 encodings
//   - load controller FSM state type
//   - funct3 legality and alignment helper functions
package ld_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } ld_state_t;

    // True for the five RV32I load encodings.
    function automatic logic f3_is_legal(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // Halfwords need an even address, words a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_LH, F3_LHU: return off[0];
            F3_LW:         return (off != 2'b00);
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ld_ext_unit.sv
// ld_ext_unit: combinational byte/halfword selection and sign/zero extension
// for RV32I loads. Shared with the single-cycle datapath.
// Ports:
//   rdata   in  32  little-endian memory word
//   offset  in  2   byte offset within the word (addr[1:0])
//   funct3  in  3   load funct3
//   ext_val out 32  extracted and extended value
module ld_ext_unit
    import ld_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] ext_val
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = '0;
        case (offset)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
    end

    // Halfword select ignores offset[0]; alignment is policed elsewhere.
    always_comb begin
        w_half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ext_val = rdata;
        case (funct3)
            F3_LB:   ext_val = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  ext_val = {{24{1'b0}}, w_byte};
            F3_LH:   ext_val = {{16{w_half[15]}}, w_half};
            F3_LHU:  ext_val = {{16{1'b0}}, w_half};
            default: ext_val = rdata;
        endcase
    end

endmodule

// File: rtl/ld_ext_ctrl.sv
// ld_ext_ctrl: multi-cycle load controller. Accepts a load request, issues one
// word read to data memory, extracts/extends the addressed byte/half/word and
// returns it over a valid/ready handshake. Illegal funct3 and memory timeout
// (and, when LD_MISALIGN_CHK_EN is defined, misalignment) return rsp_err=1
// with rsp_data=0.
// Optional feature macro: LD_MISALIGN_CHK_EN
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake; req_addr, req_funct3 payload
//   mem_req/mem_addr      word read request (held until mem_ack), word address
//   mem_ack/mem_rdata     read data strobe and word
//   rsp_valid/rsp_ready   response handshake; rsp_data, rsp_err payload
module ld_ext_ctrl
    import ld_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    ld_state_t          r_state;
    ld_state_t          w_next;
    logic [ADDR_W-3:0]  r_waddr;
    logic [1:0]         r_off;
    logic [2:0]         r_f3;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_data;
    logic               r_err;

    logic               w_accept;
    logic               w_reject;
    logic               w_cnt_last;
    logic [31:0]        w_ext_val;

    ld_ext_unit u_ext (
        .rdata   (mem_rdata),
        .offset  (r_off),
        .funct3  (r_f3),
        .ext_val (w_ext_val)
    );

    always_comb begin
        w_accept   = req_valid && (r_state == ST_IDLE);
        w_cnt_last = (r_cnt == CNT_LAST);
    end

`ifdef LD_MISALIGN_CHK_EN
    always_comb begin
        w_reject = !f3_is_legal(req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
    end
`else
    always_comb begin
        w_reject = !f3_is_legal(req_funct3);
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; an ack on the last WAIT cycle still goes to RESP,
    // and the datapath below gives it priority over the timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = w_reject ? ST_RESP : ST_WAIT;
            ST_WAIT: if (mem_ack || w_cnt_last) w_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        req_ready = rst_n && (r_state == ST_IDLE);
        mem_req   = (r_state == ST_WAIT);
        rsp_valid = (r_state == ST_RESP);
        mem_addr  = {r_waddr, 2'b00};
        rsp_data  = r_data;
        rsp_err   = r_err;
    end

    // Request capture, timeout counter and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_waddr <= '0;
            r_off   <= '0;
            r_f3    <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_waddr <= req_addr[ADDR_W-1:2];
                        r_off   <= req_addr[1:0];
                        r_f3    <= req_funct3;
                        r_cnt   <= '0;
                        if (w_reject) begin
                            r_data <= '0;
                            r_err  <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        r_data <= w_ext_val;
                        r_err  <= 1'b0;
                    end else if (w_cnt_last) begin
                        r_data <= '0;
                        r_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ld_ext_ctrl.md
Name: ld_ext_ctrl

Overview:
Multi-cycle load controller for the single-cycle core's load path. It accepts a load request with byte address and funct3, and issues one word read to data memory. It then extracts the addressed byte, halfword or word and sign/zero-extends it per funct3, applying the same extension rules as the immediate sz_ex unit. It returns a 32-bit result over a valid/ready handshake and flags illegal funct3, memory timeout and (optionally) misalignment.

Parameters:
ADDR_W, 32, byte-address width of req_addr/mem_addr
TIMEOUT_CYC, 16, max cycles in WAIT without mem_ack before error (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  load request valid
req_ready  out  1  controller can accept request
req_addr  in  ADDR_W  byte address
req_funct3  in  3  RV32I load funct3
mem_req  out  1  memory read request, held until mem_ack
mem_addr  out  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}
mem_ack  in  1  read data valid this cycle
mem_rdata  in  32  read word, little-endian
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_data  out  32  extended load value
rsp_err  out  1  request failed (rsp_data = 0)

Behaviour:
- Clock clk; reset rst_n is synchronous, active-low. One clock domain.
- Reset: state IDLE; mem_req=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0, timeout counter=0. req_ready=0 while rst_n low.
- req_ready = (state==IDLE). Handshake on req_valid&&req_ready; capture addr and funct3.
- FSM states: IDLE, WAIT, RESP.
- IDLE -> WAIT on accept with legal funct3: mem_req=1 next cycle, counter cleared.
- IDLE -> RESP on accept with illegal funct3 (not 000/001/010/100/101): rsp_err=1, rsp_data=0, no memory access.
- WAIT: mem_req held high, mem_addr stable.
  - mem_ack: capture and extend mem_rdata, drop mem_req, go to RESP with rsp_err=0.
  - No ack and counter==TIMEOUT_CYC-1: drop mem_req, go to RESP with rsp_err=1, rsp_data=0.
  - ack and timeout in the same cycle: ack wins.
- RESP: rsp_valid=1; rsp_data/rsp_err stable until rsp_ready. On rsp_ready, go to IDLE next cycle with rsp_valid=0. No new request is accepted in the same cycle as the response.
- Latency: accept at cycle N -> mem_req at N+1. Ack at cycle M -> rsp_valid at M+1. Minimum request-to-response is 2 cycles.
- Extract/extend, with o=addr[1:0]:
  - LB/LBU: byte mem_rdata[8*o+:8].
  - LH/LHU: half mem_rdata[16*o[1]+:16].
  - LW: full word.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
- mem_ack outside WAIT is ignored.
- rsp_ready outside RESP is ignored.
- rst_n low in any state -> IDLE next edge, discarding any in-flight request. Memory must tolerate mem_req dropping without ack.

Optional Feature:
LD_MISALIGN_CHK_EN
- Defined: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, goes IDLE -> RESP with rsp_err=1, rsp_data=0, and mem_req is never asserted.
- Undefined: no check. LH/LHU ignore addr[0]; LW ignores addr[1:0].

Decomposition:
- Shared package ld_pkg holds:
  - funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101.
  - FSM state encoding (IDLE, WAIT, RESP).
  - The legal-funct3 decode function.
- One combinational sub-module, ld_ext_unit(rdata, offset, funct3 -> ext_val), holds the byte/half selection and sign/zero extension. It is reusable by the single-cycle datapath.
- ld_ext_ctrl contains the FSM, timeout counter and registers.

Test Plan:
1. LB, addr 0x1003, mem_rdata 0x80FF1234, ack after 3 cycles -> mem_addr 0x1000, rsp_data 0xFFFFFF80, rsp_err 0, rsp_valid exactly 1 cycle after ack.
2. LHU, addr 0x2002, mem_rdata 0xBEEF0000, ack in the first WAIT cycle -> rsp_data 0x0000BEEF. Repeat as LH -> 0xFFFFBEEF.
3. funct3 011, any addr -> mem_req never asserted, rsp_valid 1 cycle after accept, rsp_err 1, rsp_data 0.
4. LW, addr 0x40, no ack -> mem_req high for TIMEOUT_CYC cycles (16), then rsp_err 1. Also drive ack exactly on the final cycle -> rsp_err 0, data 0xDEADBEEF.
5. rsp_ready held low 5 cycles in RESP -> rsp_data/rsp_err stable and req_ready 0. Then rsp_ready=1 -> req_ready 1 next cycle.
6. rst_n low for 1 cycle during WAIT -> next edge mem_req 0, rsp_valid 0, req_ready 1 after release. A later ack is ignored. With LD_MISALIGN_CHK_EN, LW at addr 0x42 -> rsp_err 1, no mem_req.
